// File: rtl/aes_pkg.sv
// AES-128 constants, S-box, GF(2^8) helpers and FSM encoding shared by the round engine.
// Latency: n/a (package). Backpressure: n/a.
// Contents: NR, AES_BLK, state_t + state constants, sbox, xtime(), mixcol().
package aes_pkg;

   localparam int NR      = 10;
   localparam int AES_BLK = 128;

   typedef logic [2:0] state_t;
   localparam state_t IDLE  = 3'd0;
   localparam state_t KWAIT = 3'd1;
   localparam state_t ADD0  = 3'd2;
   localparam state_t ROUND = 3'd3;
   localparam state_t FINAL = 3'd4;
   localparam state_t DONE  = 3'd5;

   localparam logic [7:0] sbox [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x in GF(2^8), reduction polynomial 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // One MixColumns column; row 0 byte in col[31:24].
   function automatic logic [31:0] mixcol(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_round_engine_if.sv
// Host/key-schedule side bundle of the AES round engine.
// Latency: n/a. Backpressure: none; Start is a level sampled only while the engine is idle.
// slave = engine (consumes Start/Din/KeyRy/Key), master = host/key-schedule side.
interface aes_round_engine_if;
   import aes_pkg::*;

   logic               Start;
   logic [AES_BLK-1:0] Din;
   logic               KeyRy;
   logic [AES_BLK-1:0] Key;
   logic               KeyEn;
   logic [3:0]         SelKey;
   logic               Busy;
   logic               Done;
   logic [AES_BLK-1:0] Dout;

   modport slave  (input  Start, Din, KeyRy, Key,
                   output KeyEn, SelKey, Busy, Done, Dout);
   modport master (output Start, Din, KeyRy, Key,
                   input  KeyEn, SelKey, Busy, Done, Dout);
endinterface

// File: rtl/aes_round_comb.sv
// One AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Latency: purely combinational. Backpressure: none.
// Ports: st (state in), rk (round key), last (skip MixColumns), nxt (state out).
module aes_round_comb
   import aes_pkg::*;
(
   input  logic [AES_BLK-1:0] st,
   input  logic [AES_BLK-1:0] rk,
   input  logic               last,
   output logic [AES_BLK-1:0] nxt
);

   logic [AES_BLK-1:0] sr;
   logic [AES_BLK-1:0] mc;

   // Byte i sits at row i%4, column i/4; ShiftRows pulls it from column (c+r)%4.
   for (genvar i = 0; i < 16; i++) begin : g_byte
      localparam int R   = i % 4;
      localparam int C   = i / 4;
      localparam int SRC = 4 * ((C + R) % 4) + R;
      assign sr[127-8*i -: 8] = sbox[st[127-8*SRC -: 8]];
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      assign mc[127-32*c -: 32] = mixcol(sr[127-32*c -: 32]);
   end

   assign nxt = (last ? sr : mc) ^ rk;

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor, one round per clock, keys fetched one cycle ahead.
// Latency: 13 cycles Start->Done, one block per 14 cycles. Backpressure: Start ignored unless idle and KeyRy.
// Ports: Clk, Rst (sync, active-high), bus (aes_round_engine_if.slave).
module aes_round_engine
   import aes_pkg::*;
#(
   parameter int NR = aes_pkg::NR
) (
   input  logic Clk,
   input  logic Rst,
   aes_round_engine_if.slave bus
);

   state_t             state;
   logic [AES_BLK-1:0] st;
   logic [3:0]         rnd;
   logic [3:0]         sel_key;
   logic [AES_BLK-1:0] dout;
   logic [AES_BLK-1:0] rnd_nxt;
   logic [4:0]         sel_inc;

   aes_round_comb u_round (
      .st   (st),
      .rk   (bus.Key),
      .last (state == FINAL),
      .nxt  (rnd_nxt)
   );

   // In ROUND r the key for r+1 is requested; the index saturates at NR so
   // FINAL still sees the last key.
   assign sel_inc = {1'b0, rnd} + 5'd2;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state   <= IDLE;
         st      <= '0;
         rnd     <= '0;
         sel_key <= '0;
         dout    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Start && bus.KeyRy) begin
                  st      <= bus.Din;
                  sel_key <= 4'd0;
                  state   <= KWAIT;
               end
            end
            KWAIT: begin
               sel_key <= 4'd1;
               rnd     <= 4'd1;
               state   <= ADD0;
            end
            ADD0: begin
               st      <= st ^ bus.Key;
               sel_key <= 4'd2;
               state   <= ROUND;
            end
            ROUND: begin
               st      <= rnd_nxt;
               rnd     <= rnd + 4'd1;
               sel_key <= (sel_inc > 5'(NR)) ? 4'(NR) : sel_inc[3:0];
               if (rnd == 4'(NR - 1)) state <= FINAL;
            end
            FINAL: begin
               dout    <= rnd_nxt;
               sel_key <= 4'd0;
               state   <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.KeyEn  = (state == KWAIT) || (state == ADD0) || (state == ROUND);
   assign bus.Busy   = (state == KWAIT) || (state == ADD0) || (state == ROUND) || (state == FINAL);
   assign bus.Done   = (state == DONE);
   assign bus.SelKey = sel_key;
   assign bus.Dout   = dout;

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine using the FIPS-197 Appendix B vector.
// A registered round-key table stands in for the key schedule (one-cycle latency, gated by KeyEn).
module tb_aes_round_engine;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   aes_round_engine_if bus_if ();

   aes_round_engine #(.NR(10)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus_if)
   );

   localparam logic [127:0] PT    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT    = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] ALT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] ST_A0 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] ST_R1 = 128'ha49c7ff2689f352b6b5bea43026a5049;

   logic [127:0] rk_tab [0:10];
   initial begin
      rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
      rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   end

   // Key schedule model: Key at t+1 follows SelKey at t while enabled.
   initial bus_if.Key = '0;
   always @(posedge Clk) begin
      if (bus_if.KeyEn)
         bus_if.Key <= (bus_if.SelKey <= 4'd10) ? rk_tab[bus_if.SelKey] : '0;
   end

   int n_cmp = 0;
   int n_err = 0;
   int cyc;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   task automatic chk_idle(input string pfx);
      chk({pfx, " Busy"},   128'(bus_if.Busy),   128'd0);
      chk({pfx, " Done"},   128'(bus_if.Done),   128'd0);
      chk({pfx, " KeyEn"},  128'(bus_if.KeyEn),  128'd0);
      chk({pfx, " SelKey"}, 128'(bus_if.SelKey), 128'd0);
      chk({pfx, " Dout"},   bus_if.Dout,         128'd0);
   endtask

   // Caller has just stepped past the accepting edge (cycle 1); runs until Done.
   task automatic wait_done(input string pfx);
      int n;
      n = 1;
      while (!bus_if.Done && n < 40) begin
         step();
         n++;
      end
      chk({pfx, " latency"}, 128'(n), 128'd13);
      chk({pfx, " Dout"}, bus_if.Dout, CT);
   endtask

   int done_cnt;
   int exp_sel;

   initial begin
      bus_if.Start = 1'b0;
      bus_if.Din   = '0;
      bus_if.KeyRy = 1'b1;
      cyc = 0;

      // Reset state
      Rst = 1'b1;
      step(); step();
      chk_idle("reset");
      chk("reset st", dut.st, 128'd0);
      Rst = 1'b0;
      step();

      // Vectors 1/2: full trace of one block
      bus_if.Din = PT;
      bus_if.Start = 1'b1;
      step();
      bus_if.Start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         exp_sel = (c > 12) ? 0 : ((c - 1 > 10) ? 10 : c - 1);
         chk($sformatf("t1 SelKey c%0d", c), 128'(bus_if.SelKey), 128'(exp_sel));
         chk($sformatf("t1 KeyEn c%0d", c),  128'(bus_if.KeyEn),  128'(c <= 11));
         chk($sformatf("t1 Busy c%0d", c),   128'(bus_if.Busy),   128'(c <= 12));
         chk($sformatf("t1 Done c%0d", c),   128'(bus_if.Done),   128'(c == 13));
         if (c == 3) chk("t2 st after ADD0", dut.st, ST_A0);
         if (c == 4) chk("t2 st after round 1", dut.st, ST_R1);
         if (c >= 13) chk($sformatf("t1 Dout c%0d", c), bus_if.Dout, CT);
         if (c < 14) step();
      end

      // Vector 3: Start pulses while busy are ignored
      bus_if.Din = PT;
      bus_if.Start = 1'b1;
      step();
      bus_if.Start = 1'b0;
      done_cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         if (bus_if.Done) done_cnt++;
         if (c == 13) chk("t3 Dout at done", bus_if.Dout, CT);
         bus_if.Start = (c == 4) || (c == 12);
         bus_if.Din   = bus_if.Start ? ALT : PT;
         step();
      end
      bus_if.Start = 1'b0;
      chk("t3 done pulses", 128'(done_cnt), 128'd1);
      chk("t3 Dout after", bus_if.Dout, CT);
      chk("t3 idle Busy", 128'(bus_if.Busy), 128'd0);

      // Vector 4: KeyRy low blocks acceptance
      Rst = 1'b1; step(); Rst = 1'b0; step();
      bus_if.KeyRy = 1'b0;
      bus_if.Start = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("t4 Busy no-key %0d", c),  128'(bus_if.Busy),  128'd0);
         chk($sformatf("t4 KeyEn no-key %0d", c), 128'(bus_if.KeyEn), 128'd0);
      end
      bus_if.KeyRy = 1'b1;
      step();
      bus_if.Start = 1'b0;
      chk("t4 Busy accepted", 128'(bus_if.Busy), 128'd1);
      wait_done("t4");

      // Vector 5: reset during cycle 6 clears everything
      step();
      bus_if.Start = 1'b1;
      step();
      bus_if.Start = 1'b0;
      for (int c = 1; c < 6; c++) step();
      chk("t5 Busy before reset", 128'(bus_if.Busy), 128'd1);
      Rst = 1'b1;
      bus_if.Start = 1'b1;
      step();
      Rst = 1'b0;
      bus_if.Start = 1'b0;
      chk_idle("t5 after reset");
      step();
      chk("t5 still idle", 128'(bus_if.Busy), 128'd0);
      bus_if.Start = 1'b1;
      step();
      bus_if.Start = 1'b0;
      wait_done("t5");

      // Vector 6: Start held high, back-to-back blocks
      step();
      bus_if.Start = 1'b1;
      step();
      wait_done("t6 first");
      done_cnt = 0;
      while (done_cnt < 30) begin
         step();
         done_cnt++;
         if (bus_if.Done) break;
         chk($sformatf("t6 Dout hold +%0d", done_cnt), bus_if.Dout, CT);
      end
      chk("t6 second done spacing", 128'(done_cnt), 128'd14);
      chk("t6 second Dout", bus_if.Dout, CT);
      bus_if.Start = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
